id_ex_stage: RTL and testbench

Pipeline register and operand-select stage that feeds the EX-stage ALU of the five-stage MIPS core. It captures decoded instruction fields from ID on each clock, resolves RAW hazards by forwarding from MEM and WB, and presents the ALU with final operands `a` and `b` plus the 5-bit control `op`. It also detects load-use hazards. On a load-use hazard it requests an ID hold and inserts a bubble.

---
 rtl/id_ex_stage_if.sv | 51 +++++
 rtl/id_ex_stage.sv | 66 ++++++
 tb/tb_id_ex_stage.sv | 139 +++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: ID-side, forwarding and EX-side signals of the ID/EX stage
interface id_ex_stage_if;
  logic        flush;
  logic        stall;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic [31:0] id_imm;
  logic [4:0]  id_alu_op;
  logic        id_alusrc;
  logic [4:0]  id_waddr;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        id_mem_write;
  logic        id_mem_to_reg;
  logic        mem_reg_write;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic        wb_reg_write;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_alu_a;
  logic [31:0] ex_alu_b;
  logic [4:0]  ex_alu_op;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_waddr;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_mem_to_reg;
  logic        lu_hold;
  modport master (
    output flush, stall, id_valid, id_pc, id_rs, id_rt, id_rs_data, id_rt_data, id_imm,
           id_alu_op, id_alusrc, id_waddr, id_reg_write, id_mem_read, id_mem_write,
           id_mem_to_reg, mem_reg_write, mem_waddr, mem_wdata, wb_reg_write, wb_waddr, wb_wdata,
    input  ex_valid, ex_pc, ex_alu_a, ex_alu_b, ex_alu_op, ex_store_data, ex_waddr,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, lu_hold
  );
  modport slave (
    input  flush, stall, id_valid, id_pc, id_rs, id_rt, id_rs_data, id_rt_data, id_imm,
           id_alu_op, id_alusrc, id_waddr, id_reg_write, id_mem_read, id_mem_write,
           id_mem_to_reg, mem_reg_write, mem_waddr, mem_wdata, wb_reg_write, wb_waddr, wb_wdata,
    output ex_valid, ex_pc, ex_alu_a, ex_alu_b, ex_alu_op, ex_store_data, ex_waddr,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, lu_hold
  );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with MEM/WB forwarding and load-use bubble insertion
module id_ex_stage (
  input logic         clk,
  input logic         resetn,
  id_ex_stage_if.slave bus
);
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  alu_op;
    logic        alusrc;
    logic [4:0]  waddr;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
  } ex_t;
  ex_t q, d;
  logic [31:0] fa, fb;
  always_comb begin
    d = '0;
    d.valid = bus.id_valid;
    d.pc = bus.id_pc;
    d.rs = bus.id_rs;
    d.rt = bus.id_rt;
    d.rs_data = bus.id_rs_data;
    d.rt_data = bus.id_rt_data;
    d.imm = bus.id_imm;
    d.alu_op = bus.id_alu_op;
    d.alusrc = bus.id_alusrc;
    d.waddr = bus.id_waddr;
    d.reg_write = bus.id_reg_write & bus.id_valid;
    d.mem_read = bus.id_mem_read & bus.id_valid;
    d.mem_write = bus.id_mem_write & bus.id_valid;
    d.mem_to_reg = bus.id_mem_to_reg & bus.id_valid;
  end
  // a bubble is the all-zero record
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) q <= '0;
    else if (bus.flush) q <= '0;
    else if (!bus.stall) q <= bus.lu_hold ? '0 : d;
  always_comb begin
    fa = (bus.mem_reg_write && bus.mem_waddr != 5'd0 && bus.mem_waddr == q.rs) ? bus.mem_wdata :
         (bus.wb_reg_write && bus.wb_waddr != 5'd0 && bus.wb_waddr == q.rs) ? bus.wb_wdata : q.rs_data;
    fb = (bus.mem_reg_write && bus.mem_waddr != 5'd0 && bus.mem_waddr == q.rt) ? bus.mem_wdata :
         (bus.wb_reg_write && bus.wb_waddr != 5'd0 && bus.wb_waddr == q.rt) ? bus.wb_wdata : q.rt_data;
  end
  assign bus.ex_valid = q.valid;
  assign bus.ex_pc = q.pc;
  assign bus.ex_alu_a = fa;
  assign bus.ex_alu_b = q.alusrc ? q.imm : fb;
  assign bus.ex_alu_op = q.alu_op;
  assign bus.ex_store_data = fb;
  assign bus.ex_waddr = q.waddr;
  assign bus.ex_reg_write = q.reg_write;
  assign bus.ex_mem_read = q.mem_read;
  assign bus.ex_mem_write = q.mem_write;
  assign bus.ex_mem_to_reg = q.mem_to_reg;
  assign bus.lu_hold = q.valid & q.mem_read & (q.waddr != 5'd0) & bus.id_valid &
                       ((q.waddr == bus.id_rs) | (q.waddr == bus.id_rt));
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed checks of capture, forwarding, load-use, flush and stall
module tb_id_ex_stage;
  localparam logic [4:0] AND_CONTROL = 5'd4;
  localparam logic [4:0] LUI_CONTROL = 5'd13;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int pass_cnt = 0;
  int total = 0;
  id_ex_stage_if bus ();
  id_ex_stage dut (.clk(clk), .resetn(resetn), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    bus.flush = 0; bus.stall = 0; bus.id_valid = 0; bus.id_pc = 0; bus.id_rs = 0; bus.id_rt = 0;
    bus.id_rs_data = 0; bus.id_rt_data = 0; bus.id_imm = 0; bus.id_alu_op = 0; bus.id_alusrc = 0;
    bus.id_waddr = 0; bus.id_reg_write = 0; bus.id_mem_read = 0; bus.id_mem_write = 0;
    bus.id_mem_to_reg = 0; bus.mem_reg_write = 0; bus.mem_waddr = 0; bus.mem_wdata = 0;
    bus.wb_reg_write = 0; bus.wb_waddr = 0; bus.wb_wdata = 0;
  endtask
  task automatic instr(input logic [31:0] pc, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [31:0] rsd, input logic [31:0] rtd, input logic [4:0] op,
                       input logic [4:0] wa);
    bus.id_valid = 1; bus.id_pc = pc; bus.id_rs = rs; bus.id_rt = rt; bus.id_rs_data = rsd;
    bus.id_rt_data = rtd; bus.id_alu_op = op; bus.id_waddr = wa; bus.id_reg_write = 1;
    bus.id_mem_read = 0; bus.id_mem_write = 0; bus.id_mem_to_reg = 0; bus.id_alusrc = 0;
    bus.id_imm = 0;
  endtask
  initial begin
    idle();
    step();
    step();
    chk("reset_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("reset_alu_a", bus.ex_alu_a, 32'd0);
    @(negedge clk);
    resetn = 1;
    instr(32'h100, 5'd1, 5'd2, 32'h0000_00F0, 32'h0000_000F, AND_CONTROL, 5'd4);
    step();
    chk("cap_alu_a", bus.ex_alu_a, 32'h0000_00F0);
    chk("cap_alu_b", bus.ex_alu_b, 32'h0000_000F);
    chk("cap_alu_op", {27'd0, bus.ex_alu_op}, {27'd0, AND_CONTROL});
    chk("cap_pc", bus.ex_pc, 32'h100);
    chk("cap_ctrl", {27'd0, bus.ex_valid, bus.ex_reg_write, bus.ex_waddr == 5'd4, bus.ex_mem_read, bus.ex_mem_write}, 32'b11100);
    #3 resetn = 0;
    #1;
    chk("async_rst_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("async_rst_alu_a", bus.ex_alu_a, 32'd0);
    chk("async_rst_pc", bus.ex_pc, 32'd0);
    chk("async_rst_op", {27'd0, bus.ex_alu_op}, 32'd0);
    @(negedge clk);
    resetn = 1;
    step();
    chk("post_rst_alu_a", bus.ex_alu_a, 32'h0000_00F0);
    chk("post_rst_alu_op", {27'd0, bus.ex_alu_op}, {27'd0, AND_CONTROL});
    instr(32'h104, 5'd3, 5'd6, 32'h1111_1111, 32'h66, AND_CONTROL, 5'd7);
    bus.mem_reg_write = 1; bus.mem_waddr = 5'd3; bus.mem_wdata = 32'hAAAA_0000;
    bus.wb_reg_write = 1; bus.wb_waddr = 5'd3; bus.wb_wdata = 32'h5555_0000;
    step();
    chk("fwd_mem_wins", bus.ex_alu_a, 32'hAAAA_0000);
    chk("fwd_b_none", bus.ex_alu_b, 32'h66);
    bus.mem_reg_write = 0;
    #1;
    chk("fwd_wb", bus.ex_alu_a, 32'h5555_0000);
    bus.wb_reg_write = 0;
    #1;
    chk("fwd_none", bus.ex_alu_a, 32'h1111_1111);
    instr(32'h108, 5'd1, 5'd0, 32'h1, 32'h0, AND_CONTROL, 5'd2);
    bus.mem_reg_write = 1; bus.mem_waddr = 5'd0; bus.mem_wdata = 32'hFFFF_FFFF;
    bus.wb_reg_write = 1; bus.wb_waddr = 5'd0; bus.wb_wdata = 32'hFFFF_FFFF;
    step();
    chk("r0_guard_b", bus.ex_alu_b, 32'd0);
    chk("r0_guard_store", bus.ex_store_data, 32'd0);
    bus.wb_reg_write = 0;
    instr(32'h10C, 5'd0, 5'd7, 32'h0, 32'h0, LUI_CONTROL, 5'd8);
    bus.id_alusrc = 1; bus.id_imm = 32'h0000_1234;
    bus.mem_reg_write = 1; bus.mem_waddr = 5'd7; bus.mem_wdata = 32'hDEAD_BEEF;
    step();
    chk("lui_b_imm", bus.ex_alu_b, 32'h0000_1234);
    chk("lui_store_fwd", bus.ex_store_data, 32'hDEAD_BEEF);
    chk("lui_op", {27'd0, bus.ex_alu_op}, {27'd0, LUI_CONTROL});
    bus.mem_reg_write = 0;
    instr(32'h110, 5'd1, 5'd2, 32'h1, 32'h2, AND_CONTROL, 5'd9);
    bus.id_valid = 0; bus.id_mem_write = 1; bus.id_mem_read = 1; bus.id_mem_to_reg = 1;
    step();
    chk("invalid_gated", {28'd0, bus.ex_valid, bus.ex_reg_write, bus.ex_mem_write, bus.ex_mem_to_reg}, 32'd0);
    chk("invalid_no_hold", {31'd0, bus.lu_hold}, 32'd0);
    instr(32'h200, 5'd1, 5'd0, 32'h100, 32'h0, AND_CONTROL, 5'd5);
    bus.id_mem_read = 1; bus.id_mem_to_reg = 1; bus.id_alusrc = 1; bus.id_imm = 32'h8;
    step();
    instr(32'h204, 5'd5, 5'd9, 32'h12, 32'h99, AND_CONTROL, 5'd10);
    #1;
    chk("lu_hold_set", {31'd0, bus.lu_hold}, 32'd1);
    step();
    chk("lu_bubble_ctrl", {27'd0, bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_mem_to_reg}, 32'd0);
    chk("lu_bubble_op_pc", {bus.ex_pc[26:0], bus.ex_alu_op}, 32'd0);
    chk("lu_hold_clear", {31'd0, bus.lu_hold}, 32'd0);
    bus.mem_reg_write = 1; bus.mem_waddr = 5'd5; bus.mem_wdata = 32'h0000_CAFE;
    step();
    chk("lu_dep_pc", bus.ex_pc, 32'h204);
    chk("lu_dep_fwd", bus.ex_alu_a, 32'h0000_CAFE);
    bus.mem_reg_write = 0;
    instr(32'h300, 5'd1, 5'd2, 32'h3, 32'h4, AND_CONTROL, 5'd6);
    bus.flush = 1; bus.stall = 1;
    step();
    chk("flush_stall_ctrl", {30'd0, bus.ex_valid, bus.ex_reg_write}, 32'd0);
    bus.flush = 0; bus.stall = 0;
    instr(32'h400, 5'd2, 5'd3, 32'h44, 32'h33, AND_CONTROL, 5'd8);
    step();
    chk("pre_stall_pc", bus.ex_pc, 32'h400);
    instr(32'h500, 5'd4, 5'd5, 32'h55, 32'h66, LUI_CONTROL, 5'd12);
    bus.stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", bus.ex_pc, 32'h400);
      chk("stall_alu_a", bus.ex_alu_a, 32'h44);
    end
    bus.stall = 0;
    instr(32'h600, 5'd1, 5'd2, 32'h1, 32'h2, AND_CONTROL, 5'd11);
    bus.id_mem_read = 1;
    step();
    instr(32'h604, 5'd3, 5'd11, 32'h3, 32'h4, AND_CONTROL, 5'd13);
    bus.stall = 1;
    step();
    chk("stall_lu_keep_load", {26'd0, bus.ex_mem_read, bus.ex_waddr}, {26'd0, 1'b1, 5'd11});
    chk("stall_lu_hold", {31'd0, bus.lu_hold}, 32'd1);
    bus.stall = 0; bus.flush = 1;
    step();
    chk("flush_alone", {31'd0, bus.ex_valid}, 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
